// File: rtl/video_pkg.sv
// Shared timing constants for the video timing generator (640x480 defaults).
// Also holds the colour-bar geometry used when VIDEO_TEST_PATTERN_EN is defined.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  localparam int DEF_COLOR_W = 3;
  localparam int DEF_CNT_W   = 12;

  localparam int BAR_COUNT = 8;
  localparam int BAR_IDX_W = 3;

  typedef logic [BAR_IDX_W-1:0] bar_idx_t;

  // Narrow active areas still get one-pixel bars.
  function automatic int bar_width(input int h_active);
    return (h_active >= BAR_COUNT) ? h_active / BAR_COUNT : 1;
  endfunction

endpackage

// File: rtl/video_bar_pattern.sv
// Eight vertical colour bars; bar index tracked by a per-line counter.
// Instantiated only when VIDEO_TEST_PATTERN_EN is defined.
module video_bar_pattern
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_TOTAL  = 800,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [CNT_W-1:0]   h,
  input  logic [CNT_W-1:0]   v,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int BAR_W = bar_width(H_ACTIVE);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAR_W - 1);
  localparam bar_idx_t IDX_LAST = bar_idx_t'(BAR_COUNT - 1);

  logic [CNT_W-1:0] cnt;
  bar_idx_t         idx;
  logic             active;

  assign active = (h < H_ACT) && (v < V_ACT);

  // cnt/idx always describe the current h; both return to 0 with h.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (ce) begin
      if (h == H_LAST) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt == CNT_LAST && idx != IDX_LAST) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else if (idx != IDX_LAST) begin
        cnt <= cnt + 1'b1;
      end
      red   <= active ? {COLOR_W{idx[2]}} : '0;
      green <= active ? {COLOR_W{idx[1]}} : '0;
      blue  <= active ? {COLOR_W{idx[0]}} : '0;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered syncs, blank and pulses.
// Define VIDEO_TEST_PATTERN_EN to drive colour bars; otherwise colours are 0.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = POL_LOW,
  parameter bit V_POL    = POL_LOW,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (longint'(H_TOTAL) >= (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam bit H_IDLE = (H_POL != POL_HIGH);
  localparam bit V_IDLE = (V_POL != POL_HIGH);

  logic [CNT_W-1:0] h, v;
  logic h_wrap, v_wrap, active, hs_act, vs_act;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);
  assign active = (h < H_ACT) && (v < V_ACT);
  assign hs_act = (h >= HS_B) && (h < HS_E);
  assign vs_act = (v >= VS_B) && (v < VS_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + 1'b1;
      end
    end
  end

  // Outputs reflect the pre-increment counters; pulses self-clear each clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      blank       <= 1'b1;
      hsync       <= H_IDLE;
      vsync       <= V_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ce && (h == '0);
      frame_start <= ce && (h == '0) && (v == '0);
      if (ce) begin
        x     <= h;
        y     <= v;
        blank <= !active;
        hsync <= hs_act ? !H_IDLE : H_IDLE;
        vsync <= vs_act ? !V_IDLE : V_IDLE;
      end
    end
  end

`ifdef VIDEO_TEST_PATTERN_EN
  video_bar_pattern #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .H_TOTAL (H_TOTAL),
    .COLOR_W (COLOR_W),
    .CNT_W   (CNT_W)
  ) u_bars (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .h    (h),
    .v    (v),
    .red  (red),
    .green(green),
    .blue (blue)
  );
`else
  assign red   = '0;
  assign green = '0;
  assign blue  = '0;
`endif

endmodule
